traffic_phase_fsm: RTL and testbench

Intersection phase controller for a two-road (main/side) crossing. It consumes the one-cycle `tick_en` pulse generated once per second by the clock divider and sequences green, yellow and all-red phases from per-phase second counts. Main road rests on green. The side road is served only after a latched vehicle request. A flash override puts the intersection into blinking caution mode. Outputs drive the lamp drivers and a seconds-remaining display.

---
 rtl/traffic_phase_fsm.sv | 166 ++++++++++++++++
 tb/tb_traffic_phase_fsm.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm
// Phase controller for a main/side road crossing. Main road rests on green.
// The side road is served only after a vehicle request has been latched. All
// phases are timed in seconds, driven by a 1 Hz one-cycle tick_en. A flash
// override gives blinking caution lamps.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   tick_en    one-cycle 1 Hz enable
//   side_req   side-road vehicle sensor (level, clk-synchronous)
//   flash      caution override (level)
//   main_lamp  {red, yellow, green} for the main road, registered
//   side_lamp  {red, yellow, green} for the side road, registered
//   sec_left   seconds remaining in the current phase
//   phase      current state encoding
module traffic_phase_fsm #(
    parameter int GREEN_MAIN_S = 10,
    parameter int GREEN_SIDE_S = 6,
    parameter int YELLOW_S     = 3,
    parameter int ALLRED_S     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       side_req,
    input  logic       flash,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic [5:0] sec_left,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        RED_TO_SIDE = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        RED_TO_MAIN = 3'd5,
        FLASH       = 3'd6
    } state_t;

    // Clamp durations into 1..63 so a zero parameter still gives a 1 s phase.
    function automatic logic [5:0] clamp_dur(input int d);
        if (d < 1)
            return 6'd1;
        else if (d > 63)
            return 6'd63;
        else
            return 6'(d);
    endfunction

    localparam logic [5:0] T_GM = clamp_dur(GREEN_MAIN_S);
    localparam logic [5:0] T_GS = clamp_dur(GREEN_SIDE_S);
    localparam logic [5:0] T_Y  = clamp_dur(YELLOW_S);
    localparam logic [5:0] T_AR = clamp_dur(ALLRED_S);

    state_t     state, state_nx;
    logic [5:0] sec_nx;
    logic       req_pend, pend_nx;
    logic       blink, blink_nx;
    logic [2:0] main_nx, side_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RED_TO_MAIN;
            sec_left  <= T_AR;
            req_pend  <= 1'b0;
            blink     <= 1'b0;
            main_lamp <= 3'b100;
            side_lamp <= 3'b100;
        end else begin
            state     <= state_nx;
            sec_left  <= sec_nx;
            req_pend  <= pend_nx;
            blink     <= blink_nx;
            main_lamp <= main_nx;
            side_lamp <= side_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sec_nx   = sec_left;
        blink_nx = blink;
        pend_nx  = req_pend;

        // Requests are remembered in every state except FLASH, where the
        // pending flag is frozen.
        if (state != FLASH && side_req)
            pend_nx = 1'b1;

        if (flash) begin
            state_nx = FLASH;
            sec_nx   = 6'd0;
            blink_nx = (state == FLASH) ? (blink ^ tick_en) : 1'b1;
        end else if (state == FLASH) begin
            state_nx = RED_TO_MAIN;
            sec_nx   = T_AR;
            blink_nx = 1'b0;
        end else if (tick_en) begin
            if (sec_left > 6'd1) begin
                sec_nx = sec_left - 6'd1;
            end else begin
                case (state)
                    MAIN_GREEN: begin
                        if (req_pend || side_req) begin
                            state_nx = MAIN_YELLOW;
                            sec_nx   = T_Y;
                        end else begin
                            sec_nx = T_GM;
                        end
                    end
                    MAIN_YELLOW: begin
                        state_nx = RED_TO_SIDE;
                        sec_nx   = T_AR;
                    end
                    RED_TO_SIDE: begin
                        state_nx = SIDE_GREEN;
                        sec_nx   = T_GS;
                        // Entering side green serves the request; a fresh
                        // request in this very cycle is kept for next round.
                        pend_nx  = side_req;
                    end
                    SIDE_GREEN: begin
                        state_nx = SIDE_YELLOW;
                        sec_nx   = T_Y;
                    end
                    SIDE_YELLOW: begin
                        state_nx = RED_TO_MAIN;
                        sec_nx   = T_AR;
                    end
                    RED_TO_MAIN: begin
                        state_nx = MAIN_GREEN;
                        sec_nx   = T_GM;
                    end
                    default: begin
                        state_nx = RED_TO_MAIN;
                        sec_nx   = T_AR;
                    end
                endcase
            end
        end
    end

    // Lamps are decoded from the next state so they land in flops alongside it.
    always_comb begin
        main_nx = 3'b100;
        side_nx = 3'b100;
        case (state_nx)
            MAIN_GREEN:  main_nx = 3'b001;
            MAIN_YELLOW: main_nx = 3'b010;
            SIDE_GREEN:  side_nx = 3'b001;
            SIDE_YELLOW: side_nx = 3'b010;
            FLASH: begin
                main_nx = {1'b0, blink_nx, 1'b0};
                side_nx = {blink_nx, 2'b00};
            end
            default: ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
module tb_traffic_phase_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_en;
    logic       side_req;
    logic       flash;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic [5:0] sec_left;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [2:0] ph;
        logic [5:0] sec;
        logic [2:0] ml;
        logic [2:0] sl;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    traffic_phase_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .tick_en   (tick_en),
        .side_req  (side_req),
        .flash     (flash),
        .main_lamp (main_lamp),
        .side_lamp (side_lamp),
        .sec_left  (sec_left),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // Monitor: every expectation pushed at a posedge is checked at the
    // following negedge, when the registered outputs are stable.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            checks++;
            if (phase !== cur.ph || sec_left !== cur.sec ||
                main_lamp !== cur.ml || side_lamp !== cur.sl) begin
                errors++;
                $display("FAIL %s: got phase=%0d sec=%0d main=%b side=%b, want phase=%0d sec=%0d main=%b side=%b",
                         cur.name, phase, sec_left, main_lamp, side_lamp,
                         cur.ph, cur.sec, cur.ml, cur.sl);
            end
        end
    end

    // Lamp table for each phase; bl is the blink level in FLASH.
    task automatic push(input string nm, input int ph, input int sec, input bit bl);
        exp_t e;
        e.name = nm;
        e.ph   = 3'(ph);
        e.sec  = 6'(sec);
        case (ph)
            0:       begin e.ml = 3'b001; e.sl = 3'b100; end
            1:       begin e.ml = 3'b010; e.sl = 3'b100; end
            3:       begin e.ml = 3'b100; e.sl = 3'b001; end
            4:       begin e.ml = 3'b100; e.sl = 3'b010; end
            6:       begin e.ml = {1'b0, bl, 1'b0}; e.sl = {bl, 2'b00}; end
            default: begin e.ml = 3'b100; e.sl = 3'b100; end
        endcase
        sb.push_back(e);
    endtask

    // One 4-cycle second: tick on the first cycle, optional one-cycle
    // side_req on the second (away from the tick), flash held as given.
    task automatic tk(input string nm, input bit req_late, input bit fl,
                      input int ph, input int sec, input bit bl = 1'b0);
        @(negedge clk);
        tick_en = 1'b1;
        flash   = fl;
        @(posedge clk);
        push(nm, ph, sec, bl);
        @(negedge clk);
        tick_en  = 1'b0;
        side_req = req_late;
        @(negedge clk);
        side_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input string nm, input int ph, input int hi, input int lo);
        for (int s = hi; s >= lo; s--)
            tk(nm, 1'b0, 1'b0, ph, s);
    endtask

    // Full side cycle after main-green expiry, ending back in main green.
    task automatic side_cycle(input string nm);
        tk(nm, 1'b0, 1'b0, 1, 3);
        run(nm, 1, 2, 1);
        tk(nm, 1'b0, 1'b0, 2, 1);
        tk(nm, 1'b0, 1'b0, 3, 6);
        run(nm, 3, 5, 1);
        tk(nm, 1'b0, 1'b0, 4, 3);
        run(nm, 4, 2, 1);
        tk(nm, 1'b0, 1'b0, 5, 1);
        tk(nm, 1'b0, 1'b0, 0, 10);
    endtask

    initial begin
        rst      = 1'b0;
        tick_en  = 1'b0;
        side_req = 1'b0;
        flash    = 1'b0;
        repeat (3) @(posedge clk);
        push("reset", 5, 1, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Release and idle main green with re-arm.
        tk("release", 1'b0, 1'b0, 0, 10);
        for (int k = 2; k <= 25; k++)
            tk("idle_green", 1'b0, 1'b0, 0, 10 - ((k - 1) % 10));
        run("idle_green", 0, 5, 1);
        tk("green_rearm", 1'b0, 1'b0, 0, 10);
        run("idle_green", 0, 9, 8);

        // One-cycle request at second 7, served on expiry.
        tk("req_at_7", 1'b1, 1'b0, 0, 7);
        run("green_pend", 0, 6, 1);
        side_cycle("side_seq");
        run("after_side", 0, 9, 1);
        tk("pend_cleared", 1'b0, 1'b0, 0, 10);

        // Flash entered from side green on a tick cycle.
        tk("req2", 1'b1, 1'b0, 0, 9);
        run("green_pend2", 0, 8, 1);
        tk("to_side", 1'b0, 1'b0, 1, 3);
        run("to_side", 1, 2, 1);
        tk("to_side", 1'b0, 1'b0, 2, 1);
        tk("to_side", 1'b0, 1'b0, 3, 6);
        tk("to_side", 1'b0, 1'b0, 3, 5);
        tk("flash_on", 1'b0, 1'b1, 6, 0, 1'b1);
        tk("flash_blink", 1'b0, 1'b1, 6, 0, 1'b0);
        tk("flash_blink", 1'b0, 1'b1, 6, 0, 1'b1);
        tk("flash_blink", 1'b0, 1'b1, 6, 0, 1'b0);
        @(negedge clk);
        flash = 1'b0;
        @(posedge clk);
        push("flash_exit", 5, 1, 1'b0);
        tk("after_flash", 1'b0, 1'b0, 0, 10);
        run("after_flash", 0, 9, 1);
        tk("flash_no_pend", 1'b0, 1'b0, 0, 10);

        // Async reset mid main yellow with a request pending.
        tk("req3", 1'b1, 1'b0, 0, 9);
        run("green_pend3", 0, 8, 1);
        tk("main_yellow", 1'b0, 1'b0, 1, 3);
        tk("yellow_req", 1'b1, 1'b0, 1, 2);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 push("async_rst", 5, 1, 1'b0);
        #1 rst = 1'b1;
        tk("post_rst", 1'b0, 1'b0, 0, 10);
        run("post_rst", 0, 9, 1);
        tk("pend_lost", 1'b0, 1'b0, 0, 10);

        // Request during side yellow is served next round.
        tk("req4", 1'b1, 1'b0, 0, 9);
        run("green_pend4", 0, 8, 1);
        tk("sy_path", 1'b0, 1'b0, 1, 3);
        run("sy_path", 1, 2, 1);
        tk("sy_path", 1'b0, 1'b0, 2, 1);
        tk("sy_path", 1'b0, 1'b0, 3, 6);
        run("sy_path", 3, 5, 1);
        tk("sy_req", 1'b1, 1'b0, 4, 3);
        run("sy_path", 4, 2, 1);
        tk("sy_path", 1'b0, 1'b0, 5, 1);
        tk("sy_path", 1'b0, 1'b0, 0, 10);
        run("sy_green", 0, 9, 1);
        tk("served_again", 1'b0, 1'b0, 1, 3);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
